// File: rtl/mbist_addr_gen.sv
// Memory BIST address generator: walks an address window up or down, one element at a time,
// with a scan chain through the address register.
module mbist_addr_gen #(
  parameter int                      BIST_ADDR_WD    = 9,
  parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_START = 9'h000,
  parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_END   = 9'h1F8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    scan_shift,
  input  logic                    sdi,
  output logic                    sdo,
  input  logic                    run,
  input  logic                    last_op,
  input  logic                    op_updown,
  input  logic                    sti_start,
  input  logic                    re_init,
  output logic [BIST_ADDR_WD-1:0] bist_addr,
  output logic                    last_addr,
  output logic                    addr_busy,
  output logic                    addr_done
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  localparam logic [BIST_ADDR_WD-1:0] ADDR_ONE = BIST_ADDR_WD'(1);

  logic [0:0]              state_q, state_d;
  logic [BIST_ADDR_WD-1:0] addr_q, addr_d;
  logic                    done_q, done_d;
  logic [BIST_ADDR_WD-1:0] dirStart;
  logic                    step;

  // An out-of-range address also counts as terminal, so stepping can never wrap.
  assign dirStart  = op_updown ? BIST_ADDR_START : BIST_ADDR_END;
  assign last_addr = op_updown ? (addr_q >= BIST_ADDR_END) : (addr_q <= BIST_ADDR_START);
  assign step      = (state_q == ACTIVE) && run && last_op;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    if (scan_shift) begin
      addr_d = {sdi, addr_q[BIST_ADDR_WD-1:1]};
    end else if (sti_start || re_init) begin
      addr_d  = dirStart;
      state_d = ACTIVE;
    end else if (step) begin
      if (last_addr) begin
        addr_d  = dirStart;
        state_d = IDLE;
        done_d  = 1'b1;
      end else if (op_updown) begin
        addr_d = addr_q + ADDR_ONE;
      end else begin
        addr_d = addr_q - ADDR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= BIST_ADDR_START;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  assign bist_addr = addr_q;
  assign sdo       = addr_q[0];
  assign addr_busy = (state_q == ACTIVE);
  assign addr_done = done_q;

endmodule

// File: tb/tb_mbist_addr_gen.sv
// Self-checking bench for mbist_addr_gen: vector table, directed sweeps/corner sequences,
// and randomized traffic against an element-level reference model.
module tb_mbist_addr_gen;

  localparam int AW    = 9;
  localparam int START = 'h000;
  localparam int END   = 'h1F8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          scan_shift, sdi, run, last_op, op_updown, sti_start, re_init;
  logic          sdo, last_addr, addr_busy, addr_done;
  logic [AW-1:0] bist_addr;

  int checks = 0;
  int errors = 0;

  // Reference model: the element in progress, the address as a plain integer, and the done flag.
  int mAddr;
  bit mActive;
  bit mDone;

  typedef struct {
    logic scan, sdi, sti, reinit, run, lastOp, upDown;
    int   expAddr;
    logic expBusy, expDone;
  } vec_t;

  vec_t vecs[10];

  mbist_addr_gen #(
    .BIST_ADDR_WD(AW),
    .BIST_ADDR_START(9'h000),
    .BIST_ADDR_END(9'h1F8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scan_shift(scan_shift), .sdi(sdi), .sdo(sdo),
    .run(run), .last_op(last_op), .op_updown(op_updown), .sti_start(sti_start),
    .re_init(re_init), .bist_addr(bist_addr), .last_addr(last_addr),
    .addr_busy(addr_busy), .addr_done(addr_done)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic sc, input logic sd, input logic st, input logic ri,
                               input logic rn, input logic lo, input logic ud);
    scan_shift = sc; sdi = sd; sti_start = st; re_init = ri;
    run = rn; last_op = lo; op_updown = ud;
  endtask

  function automatic bit modelLast();
    return op_updown ? (mAddr >= END) : (mAddr <= START);
  endfunction

  task automatic checkOutput();
    checkVal("addr", int'(bist_addr), mAddr);
    checkVal("busy", int'(addr_busy), int'(mActive));
    checkVal("done", int'(addr_done), int'(mDone));
    checkVal("sdo", int'(sdo), mAddr % 2);
    checkVal("last_addr", int'(last_addr), int'(modelLast()));
  endtask

  task automatic modelReset();
    mAddr = START; mActive = 0; mDone = 0;
  endtask

  // Advance one clock: compute the element-level outcome from the applied inputs, then compare.
  task automatic cycle();
    int  nAddr;
    bit  nActive;
    bit  nDone;
    int  firstAddr;
    nAddr = mAddr; nActive = mActive; nDone = 0;
    firstAddr = op_updown ? START : END;
    if (scan_shift) begin
      nAddr = (int'(sdi) << (AW - 1)) + (mAddr / 2);
    end else if (sti_start || re_init) begin
      nAddr = firstAddr; nActive = 1;
    end else if (mActive && run && last_op) begin
      if (modelLast()) begin
        nAddr = firstAddr; nActive = 0; nDone = 1;
      end else begin
        nAddr = op_updown ? mAddr + 1 : mAddr - 1;
      end
    end
    @(posedge clk);
    #1;
    mAddr = nAddr; mActive = nActive; mDone = nDone;
    checkOutput();
  endtask

  initial begin
    int doneCount;
    int steps;
    int guard;
    logic [AW-1:0] prior;
    logic [AW-1:0] pattern;

    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 'h000, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 'h001, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 'h001, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 'h001, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 'h000, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 'h1F8, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 'h1F8, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 'h000, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 'h100, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 'h101, 1'b1, 1'b0};

    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    modelReset();
    @(posedge clk);
    #1;
    checkOutput();
    checkVal("reset_addr", int'(bist_addr), START);
    checkVal("reset_busy", int'(addr_busy), 0);
    rst_n = 1'b1;

    // Table of short transactions with hand-derived expectations.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].scan, vecs[i].sdi, vecs[i].sti, vecs[i].reinit,
                    vecs[i].run, vecs[i].lastOp, vecs[i].upDown);
      cycle();
      checkVal($sformatf("vec%0d_addr", i), int'(bist_addr), vecs[i].expAddr);
      checkVal($sformatf("vec%0d_busy", i), int'(addr_busy), int'(vecs[i].expBusy));
      checkVal($sformatf("vec%0d_done", i), int'(addr_done), int'(vecs[i].expDone));
    end

    // Full up sweep.
    applyStimulus(0, 0, 1, 0, 0, 0, 1);
    cycle();
    checkVal("up_start", int'(bist_addr), 'h000);
    applyStimulus(0, 0, 0, 0, 1, 1, 1);
    for (int a = 1; a <= END; a++) begin
      cycle();
      checkVal("up_addr", int'(bist_addr), a);
      checkVal("up_nodone", int'(addr_done), 0);
    end
    checkVal("up_last", int'(last_addr), 1);
    cycle();
    checkVal("up_done", int'(addr_done), 1);
    checkVal("up_wrap_addr", int'(bist_addr), 'h000);
    checkVal("up_idle", int'(addr_busy), 0);
    cycle();
    checkVal("up_done_once", int'(addr_done), 0);

    // Full down sweep.
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    cycle();
    checkVal("dn_start", int'(bist_addr), 'h1F8);
    applyStimulus(0, 0, 0, 0, 1, 1, 0);
    doneCount = 0;
    for (int a = END - 1; a >= 0; a--) begin
      cycle();
      checkVal("dn_addr", int'(bist_addr), a);
      doneCount += int'(addr_done);
    end
    checkVal("dn_last", int'(last_addr), 1);
    cycle();
    doneCount += int'(addr_done);
    cycle();
    doneCount += int'(addr_done);
    checkVal("dn_done_count", doneCount, 1);

    // Multi-op elements: last_op one cycle in three.
    applyStimulus(0, 0, 1, 0, 0, 0, 1);
    cycle();
    steps = 0;
    guard = 0;
    while (!addr_done && guard < 2000) begin
      applyStimulus(0, 0, 0, 0, 1, (guard % 3) == 2, 1);
      if (last_op && addr_busy) steps++;
      cycle();
      guard++;
    end
    checkVal("multi_finished", int'(guard < 2000), 1);
    checkVal("multi_steps", steps, 505);

    // re_init partway through an up element.
    applyStimulus(0, 0, 1, 0, 0, 0, 1);
    cycle();
    applyStimulus(0, 0, 0, 0, 1, 1, 1);
    repeat ('h50) cycle();
    checkVal("reinit_pre", int'(bist_addr), 'h050);
    applyStimulus(0, 0, 0, 1, 1, 1, 1);
    cycle();
    checkVal("reinit_addr", int'(bist_addr), 'h000);
    checkVal("reinit_busy", int'(addr_busy), 1);
    checkVal("reinit_nodone", int'(addr_done), 0);

    // Scan 0x1A5 in while the old contents come out on sdo.
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    cycle();
    prior = bist_addr;
    checkVal("scan_prior", int'(prior), 'h1F8);
    pattern = 9'h1A5;
    for (int i = 0; i < AW; i++) begin
      checkVal("scan_sdo", int'(sdo), int'(prior[i]));
      applyStimulus(1, pattern[i], 0, 0, 1, 1, 0);
      cycle();
      checkVal("scan_busy", int'(addr_busy), 1);
    end
    checkVal("scan_result", int'(bist_addr), 'h1A5);
    applyStimulus(0, 0, 0, 0, 1, 1, 0);
    cycle();
    checkVal("scan_then_step", int'(bist_addr), 'h1A4);

    // Reset asserted mid-element.
    applyStimulus(0, 0, 1, 0, 0, 0, 1);
    cycle();
    applyStimulus(0, 0, 0, 0, 1, 1, 1);
    repeat ('h100) cycle();
    checkVal("rst_pre", int'(bist_addr), 'h100);
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkVal("rst_async_addr", int'(bist_addr), 'h000);
    checkVal("rst_async_busy", int'(addr_busy), 0);
    checkVal("rst_async_done", int'(addr_done), 0);
    checkVal("rst_async_last", int'(last_addr), 0);
    @(posedge clk);
    #1;
    checkOutput();
    rst_n = 1'b1;
    cycle();
    checkVal("rst_nodone", int'(addr_done), 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 19) == 0, 1'($urandom), $urandom_range(0, 29) == 0,
                    $urandom_range(0, 49) == 0, $urandom_range(0, 4) != 0, 1'($urandom),
                    ($urandom_range(0, 19) == 0) ? ~op_updown : op_updown);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mbist_addr_gen.md
MBIST_ADDR_GEN -- requirements
Module: mbist_addr_gen

Interface
REQ-001 SHALL provide parameter BIST_ADDR_WD, default 9, meaning address width.
REQ-002 SHALL provide parameter BIST_ADDR_START, default 9'h000, meaning lowest test address.
REQ-003 SHALL provide parameter BIST_ADDR_END, default 9'h1F8, meaning highest test address.
REQ-004 SHALL provide port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL provide port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL provide port scan_shift, input, 1, scan shift enable.
REQ-007 SHALL provide port sdi, input, 1, scan data in.
REQ-008 SHALL provide port sdo, output, 1, scan data out.
REQ-009 SHALL provide port run, input, 1, BIST run enable.
REQ-010 SHALL provide port last_op, input, 1, final operation of the element at the current address, from the operation selector.
REQ-011 SHALL provide port op_updown, input, 1, address direction: 1 = up, 0 = down.
REQ-012 SHALL provide port sti_start, input, 1, single-cycle pulse starting a new stimulus element.
REQ-013 SHALL provide port re_init, input, 1, restart the current element after error correction.
REQ-014 SHALL provide port bist_addr, output, BIST_ADDR_WD, current memory test address (registered).
REQ-015 SHALL provide port last_addr, output, 1, current address is terminal for the current direction.
REQ-016 SHALL provide port addr_busy, output, 1, element in progress.
REQ-017 SHALL provide port addr_done, output, 1, single-cycle pulse when element complete.

Function
REQ-018 SHALL implement a two-state FSM: IDLE, ACTIVE; addr_busy = 1 in ACTIVE only.
REQ-019 SHALL apply per-cycle priority: scan_shift > sti_start > re_init > step.
REQ-020 SHALL, when scan_shift = 1: bist_addr <= {sdi, bist_addr[BIST_ADDR_WD-1:1]}; FSM state unchanged; addr_done <= 0.
REQ-021 SHALL drive sdo = bist_addr[0] combinationally.
REQ-022 SHALL, on sti_start: load bist_addr <= BIST_ADDR_START if op_updown = 1, else BIST_ADDR_END; enter ACTIVE; addr_done <= 0.
REQ-023 SHALL, on re_init in either state: perform the same direction-based load as REQ-022; enter ACTIVE; addr_done <= 0.
REQ-024 SHALL define step = ACTIVE && run && last_op; with run = 1 and last_op = 0 the address holds.
REQ-025 SHALL compute last_addr combinationally: op_updown ? (bist_addr >= BIST_ADDR_END) : (bist_addr <= BIST_ADDR_START), unsigned.
REQ-026 SHALL, on a step with last_addr = 0: bist_addr +1 (up) or -1 (down); stay ACTIVE.
REQ-027 SHALL, on a step with last_addr = 1: reload the direction start address per REQ-022; enter IDLE; assert addr_done for exactly the next cycle.
REQ-028 SHALL ignore run and last_op in IDLE: address holds and addr_done stays 0.
REQ-029 SHALL sample op_updown at each step, so a mid-element direction change takes effect on the next step; an out-of-range address is terminal by REQ-025.
REQ-030 SHALL never let bist_addr wrap through 0 or 2^BIST_ADDR_WD-1 during stepping.

Reset
REQ-031 SHALL, while rst_n = 0 and regardless of clock, force: FSM = IDLE, bist_addr = BIST_ADDR_START, addr_done = 0, addr_busy = 0.
REQ-032 SHALL drive, in reset, sdo = BIST_ADDR_START[0] and last_addr per REQ-025.
REQ-033 SHALL, on reset assertion mid-element, abort the element without an addr_done pulse.

Verification
REQ-034 SHALL cover the up sweep: sti_start with op_updown = 1, then run = last_op = 1 held -> bist_addr 0x000..0x1F8 in consecutive cycles; addr_done one cycle after the 0x1F8 step; bist_addr = 0x000; IDLE.
REQ-035 SHALL cover the down sweep: sti_start with op_updown = 0 -> starts 0x1F8, decrements to 0x000; last_addr = 1 at 0x000; addr_done pulses once.
REQ-036 SHALL cover multi-op elements: last_op high one cycle in three with run = 1 -> address advances only on last_op cycles; 505 steps to done.
REQ-037 SHALL cover re_init: re_init at bist_addr = 0x050 (up) -> next bist_addr = 0x000, addr_busy = 1, no addr_done.
REQ-038 SHALL cover scan: 9 cycles of scan_shift with sdi serial 0x1A5, LSB first -> bist_addr = 0x1A5; sdo emits prior contents LSB first; state unchanged; scan_shift and sti_start together -> shift wins.
REQ-039 SHALL cover reset mid-element: rst_n low at bist_addr = 0x100 -> immediate bist_addr = 0x000, addr_busy = 0, no addr_done.
